// File: rtl/counter_pkg.sv
// counter_pkg
//   Definitions shared by the up/down mode counter, its sequencer
//   (updown_seq_ctrl) and their testbenches.
//   - seq_state_t : sequencer state; its value is also the 3-bit debug phase.
//   - MODE_UP / MODE_DOWN : counter direction encoding.
//   - DEF_SZ : default counter width.
package counter_pkg;

    localparam int unsigned DEF_SZ = 8;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_UP      = 3'd2,
        ST_HOLD_HI = 3'd3,
        ST_DOWN    = 3'd4,
        ST_HOLD_LO = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_t;

    // A sequence is in progress in every state except IDLE and DONE.
    function automatic logic is_busy(input seq_state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/seq_hold_timer.sv
// seq_hold_timer
//   Loadable down-counter that measures one turn-around hold.
//   Ports:
//     clk     in  : clock, rising edge
//     reset   in  : synchronous, active-high reset (timer cleared)
//     load    in  : arm the timer; the following HOLD_CYC cycles form the hold
//     expired out : high in the last cycle of the hold (and whenever idle)
//   A load sets the timer to HOLD_CYC-1, so the first hold cycle sees that
//   value and the HOLD_CYC-th cycle sees zero, giving exactly HOLD_CYC cycles.
module seq_hold_timer #(
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int unsigned TW = $clog2(HOLD_CYC + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TW'(HOLD_CYC - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/updown_seq_ctrl.sv
// updown_seq_ctrl
//   Sequencer for the up/down mode counter: load lo, count up to hi, hold,
//   count down to lo, hold, repeat for cfg_loops sweeps, then pulse done.
//   Ports:
//     clk, reset         : clock (rising edge), synchronous active-high reset
//     start              : request pulse, honoured only in IDLE
//     cfg_lo/cfg_hi      : bounds, latched on an accepted start
//     cfg_loops          : number of up/down sweeps, latched on accepted start
//     stop               : abort request, honoured in busy states
//     count_in           : registered counter value (feedback)
//     mode               : counter direction, 0 = up, 1 = down
//     cnt_en / cnt_load  : counter step enable / load (load has priority)
//     load_val           : value to load (latched lo)
//     busy / done        : sequence in progress / one-cycle completion pulse
//     err / aborted      : completion status, valid with done
//     phase              : current state encoding, for debug
module updown_seq_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned SZ       = DEF_SZ,
    parameter int unsigned LOOPW    = 4,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SZ-1:0]    cfg_lo,
    input  logic [SZ-1:0]    cfg_hi,
    input  logic [LOOPW-1:0] cfg_loops,
    input  logic             stop,
    input  logic [SZ-1:0]    count_in,
    output logic             mode,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [SZ-1:0]    load_val,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             aborted,
    output logic [2:0]       phase
);

    seq_state_t       state, state_nxt;
    logic [SZ-1:0]    lo_q, hi_q;
    logic [LOOPW-1:0] loops_q;
    logic             mode_q;
    logic             err_q, err_nxt;
    logic             abort_q, abort_nxt;
    logic             latch_cfg;
    logic             loops_dec;
    logic             timer_load;
    logic             timer_expired;

    seq_hold_timer #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            loops_q <= '0;
            mode_q  <= MODE_UP;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            mode_q  <= mode;
            err_q   <= err_nxt;
            abort_q <= abort_nxt;
            if (latch_cfg) begin
                lo_q    <= cfg_lo;
                hi_q    <= cfg_hi;
                loops_q <= cfg_loops;
            end else if (loops_dec) begin
                loops_q <= loops_q - LOOPW'(1);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        mode       = mode_q;
        cnt_en     = 1'b0;
        cnt_load   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        aborted    = 1'b0;
        err_nxt    = err_q;
        abort_nxt  = abort_q;
        latch_cfg  = 1'b0;
        loops_dec  = 1'b0;
        timer_load = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    latch_cfg = 1'b1;
                    abort_nxt = 1'b0;
                    if ((cfg_lo >= cfg_hi) || (cfg_loops == '0)) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        err_nxt   = 1'b0;
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                mode      = MODE_UP;
                cnt_load  = 1'b1;
                state_nxt = ST_UP;
            end
            ST_UP: begin
                mode = MODE_UP;
                if (count_in != hi_q) begin
                    cnt_en = 1'b1;
                end else begin
                    timer_load = 1'b1;
                    state_nxt  = ST_HOLD_HI;
                end
            end
            ST_HOLD_HI: begin
                if (timer_expired) begin
                    state_nxt = ST_DOWN;
                end
            end
            ST_DOWN: begin
                mode = MODE_DOWN;
                if (count_in != lo_q) begin
                    cnt_en = 1'b1;
                end else begin
                    loops_dec = 1'b1;
                    // loops_q still holds the pre-decrement value here
                    if (loops_q == LOOPW'(1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        timer_load = 1'b1;
                        state_nxt  = ST_HOLD_LO;
                    end
                end
            end
            ST_HOLD_LO: begin
                if (timer_expired) begin
                    state_nxt = ST_UP;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                err       = err_q;
                aborted   = abort_q;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides everything decided above, including a bound hit
        // in the same cycle; the counter is frozen immediately.
        if (is_busy(state) && stop) begin
            cnt_en     = 1'b0;
            cnt_load   = 1'b0;
            loops_dec  = 1'b0;
            timer_load = 1'b0;
            abort_nxt  = 1'b1;
            state_nxt  = ST_DONE;
        end
    end

    assign busy     = is_busy(state);
    assign load_val = lo_q;
    assign phase    = state;

endmodule
